instr_fetch: RTL and testbench

- Upstream neighbour of the main control decoder. Holds the program counter and fetches 32-bit instructions from instruction memory using a req/ready handshake.
- Presents each instruction and its opcode field (instr[31:26]) to the control decoder and holds it until the downstream stage acknowledges it.
- On acknowledge, consumes the decoder's PcOp/Branch outputs, the ALU zero flag and the jr indication to select the next PC.

---
 rtl/instr_fetch_pkg.sv | 18 +
 rtl/instr_fetch_next_pc_sel.sv | 37 +++
 rtl/instr_fetch.sv | 113 +++++++++++
 tb/tb_instr_fetch.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage and the control decoder that drives PcOp.
// Holds the PcOp encodings, the fetch FSM states and the default reset PC.
package instr_fetch_pkg;

   localparam logic [1:0] PCOP_SEQ = 2'b00;
   localparam logic [1:0] PCOP_BEQ = 2'b01;
   localparam logic [1:0] PCOP_BNE = 2'b10;
   localparam logic [1:0] PCOP_JMP = 2'b11;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_next_pc_sel.sv
// Combinational next-PC selection: jr, then jump, then taken branch, else sequential.
// Also flags a jr target whose low two bits are not zero.
module next_pc_sel
   import instr_fetch_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [31:0] instr,
   input  logic [1:0]  PcOp,
   input  logic        Branch,
   input  logic        zero,
   input  logic        isJR,
   input  logic [31:0] jr_target,
   output logic [31:0] next_pc,
   output logic        misalign
);

   logic [31:0] br_offset;
   logic        br_taken;

   assign br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
   assign br_taken  = Branch & (((PcOp == PCOP_BEQ) & zero) |
                                ((PcOp == PCOP_BNE) & ~zero));

   always_comb begin
      next_pc = pc_plus4;
      if (isJR) begin
         next_pc = {jr_target[31:2], 2'b00};
      end else if (PcOp == PCOP_JMP) begin
         next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      end else if (br_taken) begin
         next_pc = pc_plus4 + br_offset;
      end
   end

   assign misalign = isJR & (jr_target[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a req/ready handshake and
// holds each instruction for the decoder until it is acknowledged.
//
//   state | meaning
//   BOOT  | one idle cycle after reset, no request
//   FETCH | imem_req high at imem_addr=pc, waiting for imem_ready
//   HOLD  | instr/opcode/pc presented with instr_valid, waiting for instr_ack
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic        instr_valid,
   input  logic        instr_ack,
   input  logic [1:0]  PcOp,
   input  logic        Branch,
   input  logic        zero,
   input  logic        isJR,
   input  logic [31:0] jr_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        jr_misalign,
   output logic [31:0] instr_count
);

   fetch_state_t state_q;
   logic [31:0]  pc_q;
   logic [31:0]  instr_q;
   logic [31:0]  count_q;
   logic         misalign_q;
   logic         req_q;
   logic         valid_q;
   logic [31:0]  pc_plus4_d;
   logic [31:0]  next_pc_d;
   logic         misalign_d;

   assign pc_plus4_d = pc_q + 32'd4;

   next_pc_sel u_next_pc_sel (
      .pc_plus4  (pc_plus4_d),
      .instr     (instr_q),
      .PcOp      (PcOp),
      .Branch    (Branch),
      .zero      (zero),
      .isJR      (isJR),
      .jr_target (jr_target),
      .next_pc   (next_pc_d),
      .misalign  (misalign_d)
   );

   // Outputs are registered alongside the state so req/valid never glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         count_q    <= '0;
         misalign_q <= 1'b0;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         misalign_q <= 1'b0;
         case (state_q)
            BOOT: begin
               state_q <= FETCH;
               req_q   <= 1'b1;
            end
            FETCH: begin
               if (imem_ready) begin
                  instr_q <= imem_rdata;
                  state_q <= HOLD;
                  req_q   <= 1'b0;
                  valid_q <= 1'b1;
               end
            end
            HOLD: begin
               if (instr_ack) begin
                  pc_q       <= next_pc_d;
                  count_q    <= count_q + 32'd1;
                  misalign_q <= misalign_d;
                  state_q    <= FETCH;
                  req_q      <= 1'b1;
                  valid_q    <= 1'b0;
               end
            end
            default: begin
               state_q <= BOOT;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[31:26];
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign pc_plus4    = pc_plus4_d;
   assign jr_misalign = misalign_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a scoreboard queue of expected fetch
// address/instruction pairs plus a small next-PC reference model.
module tb_instr_fetch;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic        instr_valid;
   logic        instr_ack;
   logic [1:0]  PcOp;
   logic        Branch;
   logic        zero;
   logic        isJR;
   logic [31:0] jr_target;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        jr_misalign;
   logic [31:0] instr_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] word;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model_pc;
   logic [31:0] model_count;

   instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .opcode      (opcode),
      .instr_valid (instr_valid),
      .instr_ack   (instr_ack),
      .PcOp        (PcOp),
      .Branch      (Branch),
      .zero        (zero),
      .isJR        (isJR),
      .jr_target   (jr_target),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .jr_misalign (jr_misalign),
      .instr_count (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model_next(input logic [31:0] cur_pc,
                                              input logic [31:0] w,
                                              input logic [1:0]  op,
                                              input logic        br,
                                              input logic        z,
                                              input logic        jr,
                                              input logic [31:0] jrt);
      logic [31:0] seq;
      logic [31:0] off;
      seq = cur_pc + 32'd4;
      off = {{16{w[15]}}, w[15:0]} * 32'd4;
      if (jr)                        return jrt & 32'hFFFF_FFFC;
      if (op == 2'b11)               return (seq & 32'hF000_0000) | ({6'd0, w[25:0]} << 2);
      if (br && op == 2'b01 && z)    return seq + off;
      if (br && op == 2'b10 && !z)   return seq + off;
      return seq;
   endfunction

   task automatic do_instr(input logic [31:0] word, input logic [1:0] op,
                           input logic br, input logic z, input logic jr,
                           input logic [31:0] jrt, input int rdy_dly,
                           input int ack_dly, input string name);
      exp_t        e;
      exp_t        got;
      int          wait_cyc;
      logic [31:0] nxt;
      logic        exp_mis;
      e.addr = model_pc;
      e.word = word;
      sb.push_back(e);
      wait_cyc = 0;
      while (!imem_req && wait_cyc < 5) begin
         @(posedge clk); #1;
         wait_cyc++;
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== e.addr) begin
         errors++;
         $display("FAIL %s fetch: req=%b addr=%h, required req=1 addr=%h", name, imem_req, imem_addr, e.addr);
      end
      for (int i = 0; i < rdy_dly; i++) begin
         imem_ready = 1'b0;
         imem_rdata = 32'hDEAD_BEEF;
         @(posedge clk); #1;
         checks++;
         if (imem_addr !== e.addr || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_stall: addr=%h valid=%b req=%b, required addr=%h valid=0 req=1", name, imem_addr, instr_valid, imem_req, e.addr);
         end
      end
      imem_ready = 1'b1;
      imem_rdata = word;
      @(posedge clk); #1;
      imem_ready = 1'b0;
      imem_rdata = 32'h0;
      checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL %s hold_latency: valid=%b req=%b, required valid=1 req=0", name, instr_valid, imem_req);
      end
      got = sb.pop_front();
      checks++;
      if (instr !== got.word || opcode !== got.word[31:26] || pc !== got.addr || pc_plus4 !== got.addr + 32'd4) begin
         errors++;
         $display("FAIL %s present: instr=%h opcode=%h pc=%h pc_plus4=%h, required instr=%h opcode=%h pc=%h pc_plus4=%h",
                  name, instr, opcode, pc, pc_plus4, got.word, got.word[31:26], got.addr, got.addr + 32'd4);
      end
      for (int i = 0; i < ack_dly; i++) begin
         instr_ack = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (instr !== got.word || pc !== got.addr || instr_count !== model_count || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s ack_stall: instr=%h pc=%h count=%0d valid=%b, required instr=%h pc=%h count=%0d valid=1",
                     name, instr, pc, instr_count, instr_valid, got.word, got.addr, model_count);
         end
      end
      PcOp = op; Branch = br; zero = z; isJR = jr; jr_target = jrt;
      instr_ack = 1'b1;
      nxt = model_next(model_pc, word, op, br, z, jr, jrt);
      exp_mis = jr && (jrt[1:0] != 2'b00);
      @(posedge clk); #1;
      instr_ack = 1'b0;
      PcOp = 2'b00; Branch = 1'b0; zero = 1'b0; isJR = 1'b0; jr_target = 32'h0;
      model_pc = nxt;
      model_count = model_count + 32'd1;
      checks++;
      if (pc !== model_pc || imem_addr !== model_pc || instr_count !== model_count ||
          instr_valid !== 1'b0 || imem_req !== 1'b1 || jr_misalign !== exp_mis) begin
         errors++;
         $display("FAIL %s after_ack: pc=%h addr=%h count=%0d valid=%b req=%b mis=%b, required pc=%h count=%0d valid=0 req=1 mis=%b",
                  name, pc, imem_addr, instr_count, instr_valid, imem_req, jr_misalign, model_pc, model_count, exp_mis);
      end
      @(posedge clk); #1;
      checks++;
      if (jr_misalign !== 1'b0 || imem_addr !== model_pc) begin
         errors++;
         $display("FAIL %s misalign_drop: mis=%b addr=%h, required mis=0 addr=%h", name, jr_misalign, imem_addr, model_pc);
      end
   endtask

   task automatic goto_pc(input logic [31:0] target);
      do_instr(32'h03E0_0008, 2'b00, 1'b0, 1'b0, 1'b1, target, 0, 0, "jr_setup");
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0 ||
          instr_count !== 32'h0 || jr_misalign !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: req=%b valid=%b pc=%h instr=%h count=%0d mis=%b, required all zero",
                  imem_req, instr_valid, pc, instr, instr_count, jr_misalign);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL boot_no_req: req=%b, required 0", imem_req);
      end
      @(posedge clk); #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL first_fetch: req=%b addr=%h, required req=1 addr=00000000", imem_req, imem_addr);
      end
      model_pc = 32'h0;
      model_count = 32'h0;
   endtask

   task automatic test_sequential();
      do_instr(32'h2008_0005, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0, "addi_seq");
      checks++;
      if (model_pc !== 32'h4 || instr_count !== 32'd1) begin
         errors++;
         $display("FAIL seq_first: pc=%h count=%0d, required pc=00000004 count=1", pc, instr_count);
      end
   endtask

   task automatic test_branches();
      goto_pc(32'h10);
      do_instr(32'h1000_FFFC, 2'b01, 1'b1, 1'b1, 1'b0, 32'h0, 0, 0, "beq_taken");
      checks++;
      if (pc !== 32'h4) begin
         errors++;
         $display("FAIL beq_taken_pc: pc=%h, required 00000004", pc);
      end
      goto_pc(32'h10);
      do_instr(32'h1000_FFFC, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0, "beq_not_taken");
      checks++;
      if (pc !== 32'h14) begin
         errors++;
         $display("FAIL beq_not_taken_pc: pc=%h, required 00000014", pc);
      end
      goto_pc(32'h10);
      do_instr(32'h1400_FFFC, 2'b10, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0, "bne_taken");
      checks++;
      if (pc !== 32'h4) begin
         errors++;
         $display("FAIL bne_taken_pc: pc=%h, required 00000004", pc);
      end
      do_instr(32'h1400_0010, 2'b10, 1'b1, 1'b1, 1'b0, 32'h0, 0, 0, "bne_not_taken");
      do_instr(32'h1000_0010, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0, "beq_no_branch_flag");
      do_instr(32'h1000_0003, 2'b01, 1'b1, 1'b1, 1'b0, 32'h0, 0, 0, "beq_forward");
   endtask

   task automatic test_jumps();
      goto_pc(32'h4000_0000);
      do_instr(32'h0800_0010, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0, "j");
      checks++;
      if (pc !== 32'h4000_0040) begin
         errors++;
         $display("FAIL j_pc: pc=%h, required 40000040", pc);
      end
      do_instr(32'h0C00_0020, 2'b11, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0, "jal");
      do_instr(32'h03E0_0008, 2'b11, 1'b1, 1'b1, 1'b1, 32'h0000_0102, 0, 0, "jr_misaligned");
      checks++;
      if (pc !== 32'h100) begin
         errors++;
         $display("FAIL jr_pc: pc=%h, required 00000100", pc);
      end
   endtask

   task automatic test_stalls();
      do_instr(32'h0109_5020, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 3, 4, "stall_both");
      do_instr(32'h8C48_0004, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1, 1, "stall_short");
   endtask

   task automatic test_wrap();
      goto_pc(32'hFFFF_FFFC);
      do_instr(32'h0000_0000, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0, "wrap_seq");
      checks++;
      if (pc !== 32'h0) begin
         errors++;
         $display("FAIL wrap_pc: pc=%h, required 00000000", pc);
      end
   endtask

   task automatic test_reset_in_hold();
      imem_ready = 1'b1;
      imem_rdata = 32'h2009_0007;
      @(posedge clk); #1;
      imem_ready = 1'b0;
      checks++;
      if (instr_valid !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_hold: valid=%b, required 1", instr_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (instr_valid !== 1'b0 || pc !== 32'h0 || instr_count !== 32'h0 || imem_req !== 1'b0 || instr !== 32'h0) begin
         errors++;
         $display("FAIL reset_in_hold: valid=%b pc=%h count=%0d req=%b instr=%h, required valid=0 pc=0 count=0 req=0 instr=0",
                  instr_valid, pc, instr_count, imem_req, instr);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL boot_after_reset: req=%b valid=%b, required req=0 valid=0", imem_req, instr_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL fetch_after_reset: req=%b addr=%h, required req=1 addr=00000000", imem_req, imem_addr);
      end
      model_pc = 32'h0;
      model_count = 32'h0;
      do_instr(32'h2008_0001, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0, "post_reset_seq");
   endtask

   initial begin
      rst_n = 1'b0;
      imem_ready = 1'b1;
      imem_rdata = 32'h0;
      instr_ack = 1'b0;
      PcOp = 2'b00;
      Branch = 1'b0;
      zero = 1'b0;
      isJR = 1'b0;
      jr_target = 32'h0;
      model_pc = 32'h0;
      model_count = 32'h0;
      test_reset();
      test_sequential();
      test_branches();
      test_jumps();
      test_stalls();
      test_wrap();
      test_reset_in_hold();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
